// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel fractional clock-enable generator.
// A synchronised PLL lock indicator is qualified over a stretch of
// consecutive locked cycles before the core is released. Each channel then
// runs a phase accumulator that emits single-cycle enables at inc/mod of
// refclk.
module clk_en_gen #(
  parameter int CHANNELS     = 2,
  parameter int ACC_W        = 24,
  parameter int LOCK_STRETCH = 1024,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      refclk,
  input  logic                      rst_n,
  input  logic                      pll_locked,
  input  logic                      cfg_load,
  input  logic [CHANNELS*ACC_W-1:0] cfg_inc,
  input  logic [CHANNELS*ACC_W-1:0] cfg_mod,
  output logic [CHANNELS-1:0]       ce,
  output logic                      core_rst,
  output logic                      locked
);

  localparam int CNT_W = $clog2(LOCK_STRETCH + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                 lk_s;
  logic                 run_ok;

  assign lk_s   = sync[SYNC_STAGES-1];
  // Accumulators only advance while running with lock still present; the
  // lock-loss edge itself clears them together with the FSM exit.
  assign run_ok = (state == RUN) && lk_s;

  // Bring the asynchronous PLL lock flag into the refclk domain.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Lock qualification FSM: the sample that leaves WAIT_LOCK counts as the
  // first of LOCK_STRETCH consecutive locked cycles, so release lands
  // SYNC_STAGES + LOCK_STRETCH edges after pll_locked rises.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      locked   <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (lk_s) begin
            if (LOCK_STRETCH == 1) begin
              state    <= RUN;
              locked   <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= STRETCH;
            end
          end
        end
        STRETCH: begin
          if (!lk_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CNT_W'(LOCK_STRETCH - 2)) begin
            state    <= RUN;
            cnt      <= cnt + 1'b1;
            locked   <= 1'b1;
            core_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk_s) begin
            state    <= WAIT_LOCK;
            cnt      <= '0;
            locked   <= 1'b0;
            core_rst <= 1'b1;
          end
        end
        default: begin
          state    <= WAIT_LOCK;
          cnt      <= '0;
          locked   <= 1'b0;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_sh;
    logic [ACC_W-1:0] mod_sh;
    logic [ACC_W:0]   sum;
    logic             ce_r;

    // One guard bit so acc + inc never wraps before the modulus compare.
    assign sum   = {1'b0, acc} + {1'b0, inc_sh};
    assign ce[i] = ce_r;

    // Shadow config plus phase accumulator; a config load restarts phase.
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        inc_sh <= '0;
        mod_sh <= '0;
        acc    <= '0;
        ce_r   <= 1'b0;
      end else if (cfg_load) begin
        inc_sh <= cfg_inc[i*ACC_W +: ACC_W];
        mod_sh <= cfg_mod[i*ACC_W +: ACC_W];
        acc    <= '0;
        ce_r   <= 1'b0;
      end else if (!run_ok || (mod_sh == '0)) begin
        acc  <= '0;
        ce_r <= 1'b0;
      end else if (inc_sh >= mod_sh) begin
        acc  <= '0;
        ce_r <= 1'b1;
      end else if (sum >= {1'b0, mod_sh}) begin
        // acc < mod guarantees the difference fits in ACC_W bits.
        acc  <= sum[ACC_W-1:0] - mod_sh;
        ce_r <= 1'b1;
      end else begin
        acc  <= sum[ACC_W-1:0];
        ce_r <= 1'b0;
      end
    end
  end

endmodule
